// File: rtl/core_id_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct fields, ALU function codes and FSM states.
package core_id_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_func_e;

  typedef enum logic {EMPTY, FULL} state_e;

  // SUB only exists for register-register ops; SRA is selected by funct7 for both forms.
  function automatic alu_func_e alu_func(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic is_reg);
    alu_func_e f;
    unique case (f3)
      F3_ADD:  f = (is_reg && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      F3_SLL:  f = ALU_SLL;
      F3_SLT:  f = ALU_SLT;
      F3_SLTU: f = ALU_SLTU;
      F3_XOR:  f = ALU_XOR;
      F3_SR:   f = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      F3_OR:   f = ALU_OR;
      F3_AND:  f = ALU_AND;
    endcase
    return f;
  endfunction

  function automatic alu_func_e branch_func(input logic [2:0] f3);
    alu_func_e f;
    case (f3)
      F3_BLT,  F3_BGE:  f = ALU_SLT;
      F3_BLTU, F3_BGEU: f = ALU_SLTU;
      default:          f = ALU_SUB;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/core_id_dec.sv
// Combinational instruction decode: immediates, operand selection, ALU function and control flags.
module core_id_dec
  import core_id_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   op1,
  output logic [XLEN-1:0]   op2,
  output alu_func_e         func,
  output logic              reg_we,
  output logic [REG_AW-1:0] rd,
  output logic              is_load,
  output logic              is_store,
  output logic              is_branch,
  output logic              illegal,
  output logic              uses_rs1,
  output logic              uses_rs2
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            writes;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));

  always_comb begin
    imm       = '0;
    op1       = '0;
    op2       = '0;
    func      = ALU_ADD;
    writes    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        op1 = rs1_val; op2 = rs2_val; func = alu_func(f3, f7, 1'b1);
        writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: begin
        imm = imm_i; op1 = rs1_val; func = alu_func(f3, f7, 1'b0);
        op2 = (f3 == F3_SLL || f3 == F3_SR) ? XLEN'(imm_i[4:0]) : imm_i;
        writes = 1'b1; uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        imm = imm_i; op1 = rs1_val; op2 = imm_i;
        writes = 1'b1; is_load = 1'b1; uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        imm = imm_s; op1 = rs1_val; op2 = imm_s;
        is_store = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm = imm_b; op1 = rs1_val; op2 = rs2_val; func = branch_func(f3);
        is_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        imm = imm_j; op1 = pc; op2 = XLEN'(4); writes = 1'b1;
      end
      OP_JALR: begin
        imm = imm_i; op1 = rs1_val; op2 = imm_i; writes = 1'b1; uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        imm = imm_u; op2 = imm_u; writes = 1'b1;
      end
      OP_AUIPC: begin
        imm = imm_u; op1 = pc; op2 = imm_u; writes = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_we = writes && (inst[11:7] != 5'(ZERO_REG));
  assign rd     = reg_we ? REG_AW'(inst[11:7]) : '0;

endmodule

// File: rtl/core_id_pipe.sv
// ID pipeline stage: EMPTY/FULL skid-less register with load-use stall and flush.
// Optional writeback forwarding is enabled by defining CORE_ID_FWD_EN.
module core_id_pipe
  import core_id_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_in,
  input  logic [XLEN-1:0]   inst_addr_in,
  input  logic              flush,
  output logic [REG_AW-1:0] read_reg1_addr_out,
  output logic [REG_AW-1:0] read_reg2_addr_out,
  input  logic [XLEN-1:0]   read_reg1_data_in,
  input  logic [XLEN-1:0]   read_reg2_data_in,
  input  logic              fwd_we_in,
  input  logic [REG_AW-1:0] fwd_addr_in,
  input  logic [XLEN-1:0]   fwd_data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_out,
  output logic [XLEN-1:0]   inst_addr_out,
  output logic              reg_we_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic [XLEN-1:0]   opnum1_out,
  output logic [XLEN-1:0]   opnum2_out,
  output logic [XLEN-1:0]   imm_out,
  output alu_func_e         func_out,
  output logic              is_load_out,
  output logic              is_store_out,
  output logic              is_branch_out,
  output logic              illegal_out
);

  state_e            state, state_nxt;
  logic [REG_AW-1:0] rs1, rs2;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic [XLEN-1:0]   d_imm, d_op1, d_op2;
  alu_func_e         d_func;
  logic              d_we, d_load, d_store, d_branch, d_illegal, d_use1, d_use2;
  logic [REG_AW-1:0] d_rd;
  logic              hazard, capture;

  assign rs1 = REG_AW'(inst_in[19:15]);
  assign rs2 = REG_AW'(inst_in[24:20]);
  assign read_reg1_addr_out = rs1;
  assign read_reg2_addr_out = rs2;

  always_comb begin
    rs1_val = (rs1 == REG_AW'(ZERO_REG)) ? '0 : read_reg1_data_in;
    rs2_val = (rs2 == REG_AW'(ZERO_REG)) ? '0 : read_reg2_data_in;
`ifdef CORE_ID_FWD_EN
    if (fwd_we_in && fwd_addr_in == rs1 && rs1 != REG_AW'(ZERO_REG)) rs1_val = fwd_data_in;
    if (fwd_we_in && fwd_addr_in == rs2 && rs2 != REG_AW'(ZERO_REG)) rs2_val = fwd_data_in;
`endif
  end

`ifndef CORE_ID_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_we_in, fwd_addr_in, fwd_data_in};
`endif

  core_id_dec #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec (
    .inst      (inst_in),
    .pc        (inst_addr_in),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (d_imm),
    .op1       (d_op1),
    .op2       (d_op2),
    .func      (d_func),
    .reg_we    (d_we),
    .rd        (d_rd),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_branch (d_branch),
    .illegal   (d_illegal),
    .uses_rs1  (d_use1),
    .uses_rs2  (d_use2)
  );

  // A load still held here cannot feed a dependent instruction; stall it one slot.
  assign hazard = (state == FULL) && is_load_out && (reg_write_addr_out != REG_AW'(ZERO_REG)) &&
                  ((d_use1 && rs1 == reg_write_addr_out) || (d_use2 && rs2 == reg_write_addr_out));

  assign in_ready  = rst && (state == EMPTY || out_ready) && !hazard;
  assign capture   = in_valid && in_ready && !flush;
  assign out_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    if (flush)                           state_nxt = EMPTY;
    else if (capture)                    state_nxt = FULL;
    else if (state == FULL && out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= EMPTY;
      inst_out           <= '0;
      inst_addr_out      <= '0;
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      opnum1_out         <= '0;
      opnum2_out         <= '0;
      imm_out            <= '0;
      func_out           <= ALU_ADD;
      is_load_out        <= 1'b0;
      is_store_out       <= 1'b0;
      is_branch_out      <= 1'b0;
      illegal_out        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        inst_out           <= inst_in;
        inst_addr_out      <= inst_addr_in;
        reg_we_out         <= d_we;
        reg_write_addr_out <= d_rd;
        opnum1_out         <= d_op1;
        opnum2_out         <= d_op2;
        imm_out            <= d_imm;
        func_out           <= d_func;
        is_load_out        <= d_load;
        is_store_out       <= d_store;
        is_branch_out      <= d_branch;
        illegal_out        <= d_illegal;
      end
    end
  end

endmodule

// File: doc/core_id_pipe.md
CORE_ID_PIPE -- requirements
Module: core_id_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32: data/address width of operands and PC.
REQ-002 SHALL provide parameter REG_AW, default 5: register address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: upstream (IF/ID) handshake.
REQ-006 SHALL have ports inst_in input 32 and inst_addr_in input XLEN: instruction word and its PC.
REQ-007 SHALL have port flush input 1: synchronous pipeline kill from branch/jump resolution.
REQ-008 SHALL have ports read_reg1_addr_out, read_reg2_addr_out output REG_AW, and read_reg1_data_in, read_reg2_data_in input XLEN: combinational register-file read.
REQ-009 SHALL have ports fwd_we_in input 1, fwd_addr_in input REG_AW, fwd_data_in input XLEN: writeback forwarding source.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1: downstream (EX) handshake.
REQ-011 SHALL have registered outputs inst_out 32, inst_addr_out XLEN, reg_we_out 1, reg_write_addr_out REG_AW, opnum1_out XLEN, opnum2_out XLEN, imm_out XLEN, func_out ALUFunc width, is_load_out 1, is_store_out 1, is_branch_out 1, illegal_out 1.

Function
REQ-012 SHALL decode R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; any other opcode SHALL set illegal_out=1, reg_we_out=0.
REQ-013 SHALL sign-extend immediates to XLEN: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; U {inst[31:12],12'b0}.
REQ-014 SHALL pick operands: R/B rs1,rs2; I-ALU/LOAD/STORE/JALR rs1,imm; JAL/AUIPC pc,(4 for JAL / U-imm for AUIPC); LUI 0,U-imm; shift-immediates use imm[4:0] zero-extended.
REQ-015 SHALL write rd only when rd!=0 and opcode writes a register (R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC).
REQ-016 SHALL implement a 2-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL compute in_ready = (EMPTY or out_ready) and not hazard.
REQ-018 SHALL capture decoded results on in_valid and in_ready, latency exactly 1 cycle inst_in -> outputs.
REQ-019 SHALL go FULL->EMPTY when out_ready=1 and no capture in the same cycle; simultaneous drain and capture SHALL stay FULL with new contents.
REQ-020 SHALL hold all outputs stable while FULL and out_ready=0.
REQ-021 SHALL assert hazard when FULL, is_load_out=1, reg_write_addr_out!=0 and it equals a source register the incoming instruction uses; exactly one bubble results.
REQ-022 SHALL, on flush=1, go EMPTY at the next edge, discard any concurrent capture; flush overrides hazard and out_ready.
REQ-023 SHALL read register x0 as 0 regardless of read_reg*_data_in.

Reset
REQ-024 SHALL, while rst=0, force FSM EMPTY, out_valid=0, all registered outputs 0, func_out=ALUFunc_ADD.
REQ-025 SHALL leave in_ready=0 during reset; first capture possible on the first edge after rst rises.

Configuration
REQ-026 SHALL honour macro CORE_ID_FWD_EN: defined -> rs operand replaced by fwd_data_in when fwd_we_in=1, fwd_addr_in==rs, rs!=0; undefined -> fwd_* ports present but ignored, register-file data used.

Structure
REQ-027 SHALL take opcode, func3, func7, ALUFunc codes, ZeroWord/ZeroReg from the shared defines.v; no local literals for them.
REQ-028 SHALL place all combinational decode in sub-module core_id_dec; core_id_pipe holds FSM, hazard, forwarding and output registers.

Verification
REQ-029 SHALL verify: addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, opnum2_out=5, reg_write_addr_out=1, func_out=ADD.
REQ-030 SHALL verify: lw x2,0(x1) then add x3,x2,x2 -> in_ready=0 for one cycle, one bubble (out_valid=0), then add issued.
REQ-031 SHALL verify: out_ready=0 for 3 cycles while FULL -> outputs unchanged, in_ready=0, no instruction lost.
REQ-032 SHALL verify: flush with in_valid=1 and FULL -> next cycle out_valid=0, flushed instruction never appears.
REQ-033 SHALL verify: beq offset -8 (0xFE000CE3) -> imm_out=0xFFFFFFF8, is_branch_out=1; opcode 0x7F -> illegal_out=1.
REQ-034 SHALL verify with CORE_ID_FWD_EN: fwd_we_in=1, fwd_addr_in=1, fwd_data_in=0xAA, add x4,x1,x0 -> opnum1_out=0xAA; without macro -> register-file value.
